compare_monitor: RTL

COMPARE_MONITOR -- requirements
Module: compare_monitor

---
 rtl/compare_monitor_pkg.sv | 23 ++
 rtl/compare_monitor_if.sv | 33 +++
 rtl/compare_monitor_sat_counter.sv | 40 ++++
 rtl/compare_monitor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/compare_monitor_pkg.sv
// compare_monitor_pkg
//   Shared types and constants for the comparator stability monitor.
//   - state_t    : qualification FSM states
//   - CODE_*     : {GT,LT,EQ} sample encodings
//   - is_onehot  : true when a sample code is a single valid flag
package compare_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUAL,
        S_STABLE
    } state_t;

    localparam logic [2:0] CODE_GT   = 3'b100;
    localparam logic [2:0] CODE_LT   = 3'b010;
    localparam logic [2:0] CODE_EQ   = 3'b001;
    localparam logic [2:0] CODE_NONE = 3'b000;

    function automatic logic is_onehot(input logic [2:0] code);
        return (code == CODE_GT) || (code == CODE_LT) || (code == CODE_EQ);
    endfunction

endpackage

// File: rtl/compare_monitor_if.sv
// compare_monitor_if
//   Groups the comparator flags, sample controls and monitor results.
//   master : drives GT/LT/EQ/en/clr, observes the results
//   slave  : the monitor; consumes the flags, drives the results
interface compare_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             GT;
    logic             LT;
    logic             EQ;
    logic             en;
    logic             clr;
    logic             stable_gt;
    logic             stable_lt;
    logic             stable_eq;
    logic             change;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic             err;

    modport master (
        output GT, LT, EQ, en, clr,
        input  stable_gt, stable_lt, stable_eq, change,
        input  gt_cnt, lt_cnt, eq_cnt, err
    );

    modport slave (
        input  GT, LT, EQ, en, clr,
        output stable_gt, stable_lt, stable_eq, change,
        output gt_cnt, lt_cnt, eq_cnt, err
    );
endinterface

// File: rtl/compare_monitor_sat_counter.sv
// sat_counter
//   Saturating up-counter for stable-declaration events.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   clr     : synchronous clear (wins over inc)
//   inc     : increment by one, holding at all-ones
//   count   : current count
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/compare_monitor.sv
// compare_monitor
//   Watches the registered GT/LT/EQ flags of an upstream comparator and
//   declares a stable result after STABLE_CYCLES identical valid samples.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : compare_monitor_if.slave
//             in : GT, LT, EQ, en (sample enable), clr (sync clear)
//             out: stable_gt/lt/eq, change pulse, gt/lt/eq_cnt, sticky err
module compare_monitor
    import compare_monitor_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    compare_monitor_if.slave     bus
);

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    logic [2:0] code;
    logic       valid;
    logic       invalid;
    logic [2:0] samp;

    state_t     state_q,  state_d;
    logic [2:0] cand_q,   cand_d;
    logic [7:0] streak_q, streak_d;
    logic [2:0] stable_q, stable_d;
    logic       change_q, change_d;
    logic       err_q,    err_d;

    logic [7:0] streak_inc;
    logic       declare;
    logic       inc_gt, inc_lt, inc_eq;

    // Invalid (multi-hot) samples are folded into "none" for the FSM.
    assign code       = {bus.GT, bus.LT, bus.EQ};
    assign valid      = is_onehot(code);
    assign invalid    = (code != CODE_NONE) && !valid;
    assign samp       = valid ? code : CODE_NONE;
    assign streak_inc = streak_q + 8'd1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cand_q   <= '0;
            streak_q <= '0;
            stable_q <= '0;
            change_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            streak_q <= streak_d;
            stable_q <= stable_d;
            change_q <= change_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        streak_d = streak_q;
        if (bus.clr) begin
            state_d  = S_IDLE;
            cand_d   = '0;
            streak_d = '0;
        end else if (bus.en) begin
            case (state_q)
                S_IDLE: begin
                    if (valid) begin
                        state_d  = S_QUAL;
                        cand_d   = samp;
                        streak_d = 8'd1;
                    end
                end
                S_QUAL: begin
                    if (!valid) begin
                        state_d  = S_IDLE;
                        streak_d = '0;
                    end else if (samp == cand_q) begin
                        streak_d = streak_inc;
                        if (streak_inc == STABLE_N) begin
                            state_d = S_STABLE;
                        end
                    end else begin
                        cand_d   = samp;
                        streak_d = 8'd1;
                    end
                end
                S_STABLE: begin
                    if (!valid) begin
                        state_d  = S_IDLE;
                        streak_d = '0;
                    end else if (samp == cand_q) begin
                        if (streak_q != 8'hFF) begin
                            streak_d = streak_inc;
                        end
                    end else begin
                        state_d  = S_QUAL;
                        cand_d   = samp;
                        streak_d = 8'd1;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    streak_d = '0;
                end
            endcase
        end
    end

    // Output logic: declaration happens on the edge that completes the streak.
    always_comb begin
        declare  = !bus.clr && bus.en && (state_q == S_QUAL) && valid &&
                   (samp == cand_q) && (streak_inc == STABLE_N);
        stable_d = stable_q;
        change_d = 1'b0;
        err_d    = err_q;
        if (bus.clr) begin
            stable_d = '0;
            err_d    = 1'b0;
        end else if (bus.en) begin
            err_d = err_q | invalid;
            if (declare) begin
                stable_d = cand_q;
                change_d = (cand_q != stable_q);
            end
        end
        inc_gt = declare && (cand_q == CODE_GT);
        inc_lt = declare && (cand_q == CODE_LT);
        inc_eq = declare && (cand_q == CODE_EQ);
    end

    sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (bus.clr),
        .inc     (inc_gt),
        .count   (bus.gt_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (bus.clr),
        .inc     (inc_lt),
        .count   (bus.lt_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (bus.clr),
        .inc     (inc_eq),
        .count   (bus.eq_cnt)
    );

    assign bus.stable_gt = stable_q[2];
    assign bus.stable_lt = stable_q[1];
    assign bus.stable_eq = stable_q[0];
    assign bus.change    = change_q;
    assign bus.err       = err_q;

endmodule
